// File: rtl/pc_fetch_ctrl.sv
`timescale 1ns/1ps
// Instruction-fetch sequencer: owns the PC, issues imem requests over req/ack,
// holds one word across IF/ID stalls and applies prioritised redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

  // The abort fires on the edge where the counter would step to TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

  state_t      r_state;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;
  logic        r_err;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_tgt;
  logic [7:0]  r_cnt;

  logic        w_redir;
  logic [31:0] w_raw_tgt;
  logic        w_misalign;
  logic [31:0] w_tgt;
  logic        w_busy;
  logic        w_timeout;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_raw_tgt = redir_target;
    if (exc_req)       w_raw_tgt = EXC_PC;
    else if (eret_req) w_raw_tgt = epc;
  end

  assign w_redir    = exc_req | eret_req | redir_valid;
  assign w_misalign = w_redir && (w_raw_tgt[1:0] != 2'b00);
  assign w_tgt      = w_misalign ? EXC_PC : w_raw_tgt;
  assign w_busy     = (r_state == S_REQ) || (r_state == S_DRAIN);
  assign w_timeout  = w_busy && !imem_ack && (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= RESET_PC;
      r_instr      <= '0;
      r_pc         <= '0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_tgt        <= '0;
      r_cnt        <= '0;
    end else begin
      r_err <= 1'b0;
      if (w_redir) begin
        r_valid      <= 1'b0;
        r_skid_instr <= '0;
        r_skid_pc    <= '0;
      end
      if (w_timeout) begin
        // Abandon the fetch (and any latched target); one idle cycle, then EXC_PC.
        r_err       <= 1'b1;
        r_imem_req  <= 1'b0;
        r_imem_addr <= EXC_PC;
        r_valid     <= 1'b0;
        r_cnt       <= '0;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_imem_req <= 1'b1;
            r_cnt      <= '0;
            if (w_redir) begin
              r_imem_addr <= w_tgt;
              r_err       <= w_misalign;
            end
            r_state <= S_REQ;
          end
          S_REQ: begin
            if (w_redir) begin
              r_err <= w_misalign;
              if (imem_ack) begin
                r_imem_addr <= w_tgt;
                r_cnt       <= '0;
              end else begin
                r_tgt   <= w_tgt;
                r_cnt   <= r_cnt + 8'd1;
                r_state <= S_DRAIN;
              end
            end else if (imem_ack) begin
              r_cnt <= '0;
              if (!r_valid || !stall) begin
                r_instr     <= imem_rdata;
                r_pc        <= r_imem_addr;
                r_valid     <= 1'b1;
                r_imem_addr <= r_imem_addr + 32'd4;
              end else begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_imem_addr;
                r_imem_req   <= 1'b0;
                r_state      <= S_HOLD;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
              if (r_valid && !stall) r_valid <= 1'b0;
            end
          end
          S_HOLD: begin
            if (w_redir) begin
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_tgt;
              r_err       <= w_misalign;
              r_cnt       <= '0;
              r_state     <= S_REQ;
            end else if (!stall) begin
              r_instr     <= r_skid_instr;
              r_pc        <= r_skid_pc;
              r_imem_req  <= 1'b1;
              r_imem_addr <= r_skid_pc + 32'd4;
              r_cnt       <= '0;
              r_state     <= S_REQ;
            end
          end
          S_DRAIN: begin
            // The returning word belongs to the squashed path and is dropped.
            if (imem_ack) begin
              r_imem_addr <= w_redir ? w_tgt : r_tgt;
              r_err       <= w_redir & w_misalign;
              r_cnt       <= '0;
              r_state     <= S_REQ;
            end else begin
              r_cnt <= r_cnt + 8'd1;
              if (w_redir) begin
                r_tgt <= w_tgt;
                r_err <= w_misalign;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr_out   = r_instr;
  assign pc_out      = r_pc;
  assign instr_valid = r_valid;
  assign fetch_err   = r_err;

endmodule
